// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV32 pipeline: the decoded control bundle
// and the values that mark register x0 and a pipeline bubble.
package cpu_pkg;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       jump;
  } ctrl_t;

  localparam logic [4:0] REG_X0      = 5'd0;
  localparam ctrl_t      CTRL_BUBBLE = ctrl_t'(10'd0);

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection: a load in EX whose destination is read by the
// instruction in ID forces a one-cycle stall, unless EX is being flushed.
module load_use_detect
  import cpu_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic       ex_reg_write,
  input  logic [4:0] ex_rd_addr,
  input  logic       id_valid,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       ex_flush,
  output logic       lu,
  output logic       id_stall
);

  // Both sources are compared regardless of format; a false stall only costs a cycle
  always_comb begin
    lu = ex_valid & ex_mem_read & ex_reg_write & (ex_rd_addr != REG_X0) & id_valid &
         ((ex_rd_addr == id_rs1_addr) | (ex_rd_addr == id_rs2_addr));
    id_stall = lu & ~ex_flush;
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with WB->ID register-file bypass, load-use bubble
// insertion and a saturating count of inserted load-use bubbles.
module id_ex_pipe_reg
  import cpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             ex_flush,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic [4:0]       id_rd_addr,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  ctrl_t            id_ctrl,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_rd_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             id_stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [4:0]       ex_rs1_addr,
  output logic [4:0]       ex_rs2_addr,
  output logic [4:0]       ex_rd_addr,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output ctrl_t            ex_ctrl,
  output logic [CNT_W-1:0] load_use_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             lu;
  logic [XLEN-1:0]  rs1_byp, rs2_byp;
  ctrl_t            cap_ctrl;

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [4:0]       rs1_addr_q, rs1_addr_d;
  logic [4:0]       rs2_addr_q, rs2_addr_d;
  logic [4:0]       rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  load_use_detect u_load_use_detect (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_reg_write(ctrl_q.reg_write),
    .ex_rd_addr  (rd_addr_q),
    .id_valid    (id_valid),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .ex_flush    (ex_flush),
    .lu          (lu),
    .id_stall    (id_stall)
  );

  // WB->ID bypass and control sanitising; reg_write on x0 is dropped so forwarding never matches it
  always_comb begin
    if (wb_reg_write && (wb_rd_addr != REG_X0) && (wb_rd_addr == id_rs1_addr)) begin
      rs1_byp = wb_data;
    end else begin
      rs1_byp = id_rs1_data;
    end
    if (wb_reg_write && (wb_rd_addr != REG_X0) && (wb_rd_addr == id_rs2_addr)) begin
      rs2_byp = wb_data;
    end else begin
      rs2_byp = id_rs2_data;
    end
    cap_ctrl = id_ctrl;
    if (!id_valid) begin
      cap_ctrl.mem_write = 1'b0;
      cap_ctrl.branch    = 1'b0;
      cap_ctrl.jump      = 1'b0;
      cap_ctrl.reg_write = 1'b0;
    end else if (id_rd_addr == REG_X0) begin
      cap_ctrl.reg_write = 1'b0;
    end else begin
      cap_ctrl = id_ctrl;
    end
  end

  // Next state: hold freezes, flush or load-use loads a bubble, otherwise capture ID
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rd_addr_d  = rd_addr_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    ctrl_d     = ctrl_q;
    cnt_d      = cnt_q;
    if (hold) begin
      cnt_d = cnt_q;
    end else if (ex_flush || lu) begin
      valid_d    = 1'b0;
      pc_d       = {XLEN{1'b0}};
      rs1_addr_d = REG_X0;
      rs2_addr_d = REG_X0;
      rd_addr_d  = REG_X0;
      rs1_data_d = {XLEN{1'b0}};
      rs2_data_d = {XLEN{1'b0}};
      imm_d      = {XLEN{1'b0}};
      ctrl_d     = CTRL_BUBBLE;
      if (!ex_flush && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      valid_d    = id_valid;
      pc_d       = id_pc;
      rs1_addr_d = id_rs1_addr;
      rs2_addr_d = id_rs2_addr;
      rd_addr_d  = id_rd_addr;
      rs1_data_d = rs1_byp;
      rs2_data_d = rs2_byp;
      imm_d      = id_imm;
      ctrl_d     = cap_ctrl;
    end
  end

  // Stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= {XLEN{1'b0}};
      rs1_addr_q <= REG_X0;
      rs2_addr_q <= REG_X0;
      rd_addr_q  <= REG_X0;
      rs1_data_q <= {XLEN{1'b0}};
      rs2_data_q <= {XLEN{1'b0}};
      imm_q      <= {XLEN{1'b0}};
      ctrl_q     <= CTRL_BUBBLE;
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_addr_q  <= rd_addr_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      ctrl_q     <= ctrl_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_pc        = pc_q;
  assign ex_rs1_addr  = rs1_addr_q;
  assign ex_rs2_addr  = rs2_addr_q;
  assign ex_rd_addr   = rd_addr_q;
  assign ex_rs1_data  = rs1_data_q;
  assign ex_rs2_data  = rs2_data_q;
  assign ex_imm       = imm_q;
  assign ex_ctrl      = ctrl_q;
  assign load_use_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg (CNT_W=2 so counter saturation is reachable):
// a reference model predicts each EX-stage update, which is compared one edge later.
module tb_id_ex_pipe_reg;
  import cpu_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    ctrl_t       ctrl;
    logic [1:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, hold, ex_flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, wb_rd_addr;
  ctrl_t       id_ctrl;
  logic        wb_reg_write;
  logic        id_stall, ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  ctrl_t       ex_ctrl;
  logic [1:0]  load_use_cnt;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t m;
  exp_t sb[$];
  logic [31:0] pc_ctr = 32'h0000_1000;

  id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .ex_flush(ex_flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_addr(ex_rs1_addr),
    .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .load_use_cnt(load_use_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic ctrl_t mk_ctrl(input logic [3:0] op, input logic src, input logic mr,
                                    input logic mw, input logic rw, input logic br, input logic jp);
    ctrl_t c;
    c.alu_op = op; c.alu_src = src; c.mem_read = mr; c.mem_write = mw;
    c.reg_write = rw; c.branch = br; c.jump = jp;
    return c;
  endfunction

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input ctrl_t c);
    id_valid = v; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_ctrl = c;
    id_pc = pc_ctr; pc_ctr = pc_ctr + 32'd4;
  endtask

  task automatic compare_out(input exp_t e);
    check_eq("ex_valid", ex_valid, e.valid);
    check_eq("ex_pc", ex_pc, e.pc);
    check_eq("ex_rs1_addr", ex_rs1_addr, e.rs1);
    check_eq("ex_rs2_addr", ex_rs2_addr, e.rs2);
    check_eq("ex_rd_addr", ex_rd_addr, e.rd);
    check_eq("ex_rs1_data", ex_rs1_data, e.d1);
    check_eq("ex_rs2_data", ex_rs2_data, e.d2);
    check_eq("ex_imm", ex_imm, e.imm);
    check_eq("ex_ctrl", ex_ctrl, e.ctrl);
    check_eq("load_use_cnt", load_use_cnt, e.cnt);
  endtask

  // Predict the stall and the next EX contents, then check them around one rising edge
  task automatic cycle();
    exp_t e;
    logic hz;
    hz = m.valid && m.ctrl.mem_read && m.ctrl.reg_write && (m.rd != 5'd0) && id_valid &&
         ((m.rd == id_rs1_addr) || (m.rd == id_rs2_addr));
    #1;
    check_eq("id_stall", id_stall, hz && !ex_flush);
    e = m;
    if (!hold) begin
      if (ex_flush) begin
        e = '0;
        e.cnt = m.cnt;
      end else if (hz) begin
        e = '0;
        e.cnt = (m.cnt == 2'd3) ? 2'd3 : m.cnt + 2'd1;
      end else begin
        e.valid = id_valid; e.pc = id_pc;
        e.rs1 = id_rs1_addr; e.rs2 = id_rs2_addr; e.rd = id_rd_addr; e.imm = id_imm;
        e.d1 = (wb_reg_write && wb_rd_addr != 5'd0 && wb_rd_addr == id_rs1_addr) ? wb_data : id_rs1_data;
        e.d2 = (wb_reg_write && wb_rd_addr != 5'd0 && wb_rd_addr == id_rs2_addr) ? wb_data : id_rs2_data;
        e.ctrl = id_ctrl;
        e.ctrl.reg_write = id_ctrl.reg_write & id_valid & (id_rd_addr != 5'd0);
        e.ctrl.mem_write = id_ctrl.mem_write & id_valid;
        e.ctrl.branch    = id_ctrl.branch & id_valid;
        e.ctrl.jump      = id_ctrl.jump & id_valid;
        e.cnt = m.cnt;
      end
    end
    m = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_nonempty", 64'd0, 64'd1);
    end else begin
      compare_out(sb.pop_front());
    end
  endtask

  initial begin
    ctrl_t c_lw, c_add, c_addi, c_br;
    c_lw   = mk_ctrl(4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    c_add  = mk_ctrl(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    c_addi = mk_ctrl(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    c_br   = mk_ctrl(4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    rst_n = 1'b0; hold = 1'b0; ex_flush = 1'b0;
    wb_reg_write = 1'b0; wb_rd_addr = 5'd0; wb_data = 32'd0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, mk_ctrl(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    m = '0;
    #12;
    check_eq("rst_ex_valid", ex_valid, 1'b0);
    check_eq("rst_cnt", load_use_cnt, 2'd0);
    check_eq("rst_stall", id_stall, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain capture
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h4, c_add); cycle();
    check_eq("cap_valid", ex_valid, 1'b1);

    // Load-use: lw x5 then add x6,x5,x7
    set_id(1'b1, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'h8, c_lw); cycle();
    set_id(1'b1, 5'd5, 5'd7, 5'd6, 32'h55, 32'h77, 32'h0, c_add);
    #1; check_eq("lu_stall", id_stall, 1'b1);
    cycle();
    check_eq("lu_bubble", ex_valid, 1'b0);
    check_eq("lu_cnt1", load_use_cnt, 2'd1);
    cycle();
    check_eq("lu_cap_valid", ex_valid, 1'b1);
    check_eq("lu_cap_rs1", ex_rs1_addr, 5'd5);

    // x0 load and x0 destination
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, c_lw); cycle();
    check_eq("x0_lw_rw", ex_ctrl.reg_write, 1'b0);
    set_id(1'b1, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 32'h0, c_add);
    #1; check_eq("x0_nostall", id_stall, 1'b0);
    cycle();
    set_id(1'b1, 5'd1, 5'd0, 5'd0, 32'h3, 32'h0, 32'h5, c_addi); cycle();
    check_eq("addi_x0_rw", ex_ctrl.reg_write, 1'b0);

    // WB bypass, then wb_rd=0 must not bypass
    wb_reg_write = 1'b1; wb_rd_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
    set_id(1'b1, 5'd1, 5'd3, 5'd4, 32'h5, 32'h0, 32'h0, c_add); cycle();
    check_eq("byp_rs2", ex_rs2_data, 32'hDEAD_BEEF);
    check_eq("byp_rs1_none", ex_rs1_data, 32'h5);
    wb_rd_addr = 5'd0;
    set_id(1'b1, 5'd0, 5'd0, 5'd4, 32'h7, 32'h9, 32'h0, c_add); cycle();
    check_eq("nobyp_rs1", ex_rs1_data, 32'h7);
    check_eq("nobyp_rs2", ex_rs2_data, 32'h9);
    wb_reg_write = 1'b0;

    // Flush together with load-use
    set_id(1'b1, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, c_lw); cycle();
    set_id(1'b1, 5'd5, 5'd7, 5'd6, 32'h1, 32'h2, 32'h0, c_add); ex_flush = 1'b1;
    #1; check_eq("flush_nostall", id_stall, 1'b0);
    cycle();
    check_eq("flush_bubble", ex_valid, 1'b0);
    check_eq("flush_cnt", load_use_cnt, 2'd1);
    ex_flush = 1'b0;

    // Hold with flush pending, then release into a bubble
    set_id(1'b1, 5'd1, 5'd2, 5'd9, 32'hA, 32'hB, 32'hC, c_add); cycle();
    hold = 1'b1; ex_flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)),
             $urandom, $urandom, $urandom, c_lw);
      cycle();
      check_eq("hold_valid", ex_valid, 1'b1);
      check_eq("hold_rd", ex_rd_addr, 5'd9);
    end
    hold = 1'b0;
    cycle();
    check_eq("hold_rel_bubble", ex_valid, 1'b0);
    ex_flush = 1'b0;

    // Invalid ID slot: side-effect controls are dropped
    set_id(1'b0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, c_br); cycle();
    check_eq("inv_branch", ex_ctrl.branch, 1'b0);

    // Saturation: five more load-use bubbles
    for (int i = 0; i < 5; i++) begin
      set_id(1'b1, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, c_lw); cycle();
      set_id(1'b1, 5'd2, 5'd5, 5'd6, 32'h0, 32'h0, 32'h0, c_add); cycle();
    end
    check_eq("sat_cnt", load_use_cnt, 2'd3);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      hold = ($urandom_range(7) == 0);
      ex_flush = ($urandom_range(7) == 0);
      wb_reg_write = $urandom_range(1);
      wb_rd_addr = 5'($urandom_range(7));
      wb_data = $urandom;
      set_id(1'($urandom_range(1)), 5'($urandom_range(7)), 5'($urandom_range(7)),
             5'($urandom_range(7)), $urandom, $urandom, $urandom, ctrl_t'(10'($urandom)));
      cycle();
    end
    hold = 1'b0; ex_flush = 1'b0; wb_reg_write = 1'b0;

    // Asynchronous reset while EX holds a real instruction
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, c_lw); cycle();
    check_eq("pre_rst_valid", ex_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", ex_valid, 1'b0);
    check_eq("mid_rst_pc", ex_pc, 32'd0);
    check_eq("mid_rst_ctrl", ex_ctrl, 10'd0);
    check_eq("mid_rst_cnt", load_use_cnt, 2'd0);
    check_eq("mid_rst_stall", id_stall, 1'b0);
    m = '0;
    set_id(1'b1, 5'd3, 5'd3, 5'd7, 32'h9, 32'h8, 32'h7, c_add);
    rst_n = 1'b1;
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
